sr_receive_ctrl: RTL and testbench



---
 rtl/srrx_pkg.sv | 25 ++
 rtl/srrx_idle_timer.sv | 33 +++
 rtl/sr_receive_ctrl.sv | 132 +++++++++++++
 tb/tb_sr_receive_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srrx_pkg.sv
// Shared types and sizing helpers for the byte-serial receive sequencer.
package srrx_pkg;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        COLLECT = 3'd1,
        SETUP   = 3'd2,
        STROBE  = 3'd3,
        FULL    = 3'd4
    } state_t;

    function automatic int nbytes_of(input int m);
        return m / 8;
    endfunction

    function automatic int cnt_width(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction

    // The idle counter only has to reach TIMEOUT-1; expiry is decoded from that value
    function automatic int idle_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/srrx_idle_timer.sv
// Inter-byte idle counter; expire is asserted combinationally on the idle cycle that reaches TIMEOUT.
module srrx_idle_timer
    import srrx_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W         = idle_width(TIMEOUT);
    localparam bit ENABLED   = (TIMEOUT > 0);
    localparam int LIMIT_INT = ENABLED ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] LIMIT = LIMIT_INT[W-1:0];

    logic [W-1:0] count;

    assign expire = ENABLED && enable && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable && ENABLED) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sr_receive_ctrl.sv
// Receive shift-register sequencer: byte handshake in, shift strobe/clear out, word handshake to consumer.
// Optional SRRX_WORD_CNT_EN adds a 16-bit delivered-word counter output.
module sr_receive_ctrl
    import srrx_pkg::*;
#(
    parameter int M       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           byte_in,
    input  logic                                 byte_valid,
    output logic                                 byte_ready,
    output logic [7:0]                           sr_in,
    output logic                                 sr_set,
    output logic                                 sr_rst,
    output logic                                 word_valid,
    input  logic                                 word_ready,
    output logic [cnt_width(nbytes_of(M))-1:0]   byte_cnt,
    output logic                                 timeout_err
`ifdef SRRX_WORD_CNT_EN
    ,
    output logic [15:0]                          word_count
`endif
);

    localparam int NBYTES = nbytes_of(M);
    localparam int CW     = cnt_width(NBYTES);
    localparam logic [CW-1:0] NB = CW'(NBYTES);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   cnt_next;
    logic [7:0]      sr_in_next;
    logic            accept;
    logic            idle_clear;
    logic            idle_enable;
    logic            expire;

    assign accept      = byte_valid && byte_ready;
    assign cnt_inc     = byte_cnt + 1'b1;
    assign idle_clear  = (state != COLLECT) || accept;
    assign idle_enable = (state == COLLECT) && (byte_cnt != '0) && !accept;

    srrx_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle_clear),
        .enable (idle_enable),
        .expire (expire)
    );

    always_comb begin
        next_state = state;
        cnt_next   = byte_cnt;
        sr_in_next = sr_in;
        case (state)
            CLEAR: begin
                next_state = COLLECT;
                cnt_next   = '0;
            end
            COLLECT: begin
                if (accept) begin
                    next_state = SETUP;
                    sr_in_next = byte_in;
                end else if (expire) begin
                    next_state = CLEAR;
                end
            end
            SETUP: begin
                next_state = STROBE;
            end
            STROBE: begin
                cnt_next   = cnt_inc;
                next_state = (cnt_inc == NB) ? FULL : COLLECT;
            end
            FULL: begin
                if (word_ready) begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
        // Byte count drops with sr_rst so it always reflects what the register really holds
        if (next_state == CLEAR) begin
            cnt_next = '0;
        end
    end

    // Every output is a registered decode of the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR;
            sr_in       <= '0;
            sr_set      <= 1'b1;
            sr_rst      <= 1'b0;
            byte_ready  <= 1'b0;
            word_valid  <= 1'b0;
            byte_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            sr_in       <= sr_in_next;
            sr_set      <= (next_state != STROBE);
            sr_rst      <= (next_state != CLEAR);
            byte_ready  <= (next_state == COLLECT);
            word_valid  <= (next_state == FULL);
            byte_cnt    <= cnt_next;
            timeout_err <= expire;
        end
    end

`ifdef SRRX_WORD_CNT_EN
    logic [15:0] word_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if ((state == FULL) && word_ready) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

    assign word_count = word_cnt;
`endif

endmodule

// File: tb/tb_sr_receive_ctrl.sv
// Self-checking bench for sr_receive_ctrl (M=32, TIMEOUT=10) with a byte scoreboard on the strobe.
module tb_sr_receive_ctrl;

    localparam int M       = 32;
    localparam int TIMEOUT = 10;
    localparam int NBYTES  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       word_ready = 1'b0;
    logic       byte_ready;
    logic [7:0] sr_in;
    logic       sr_set;
    logic       sr_rst;
    logic       word_valid;
    logic [2:0] byte_cnt;
    logic       timeout_err;
`ifdef SRRX_WORD_CNT_EN
    logic [15:0] word_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int last_acc = 0;
    logic [7:0] byte_q[$];
    logic       prev_set = 1'b1;
    logic [7:0] prev_in  = 8'h00;

    sr_receive_ctrl #(
        .M       (M),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .sr_in       (sr_in),
        .sr_set      (sr_set),
        .sr_rst      (sr_rst),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .byte_cnt    (byte_cnt),
        .timeout_err (timeout_err)
`ifdef SRRX_WORD_CNT_EN
        ,
        .word_count  (word_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must shift exactly the next accepted byte, held from the cycle before
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (sr_set === 1'b0) begin
            strobes++;
            n_checks++;
            if (byte_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL strobe_unexpected: sr_in=%h with no byte pending", sr_in);
            end else begin
                exp_b = byte_q.pop_front();
                if (sr_in !== exp_b) begin
                    n_fail++;
                    $display("[TB] FAIL strobe_data: sr_in=%h expected %h", sr_in, exp_b);
                end
            end
            n_checks++;
            if (prev_set !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL strobe_width: sr_set low for more than one cycle");
            end
            n_checks++;
            if (sr_in !== prev_in) begin
                n_fail++;
                $display("[TB] FAIL sr_in_setup: sr_in=%h at strobe, %h one cycle earlier", sr_in, prev_in);
            end
        end
        prev_set = sr_set;
        prev_in  = sr_in;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL byte_accept_wait: byte_ready=%b expected 1 within 20 cycles", byte_ready);
            byte_valid = 1'b0;
        end else begin
            byte_q.push_back(b);
            @(posedge clk);
            #1;
            last_acc   = cyc;
            byte_valid = 1'b0;
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (byte_ready !== 1'b1 && w < 20);
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_wait: byte_ready=%b expected 1 within 20 cycles", byte_ready);
        end
    endtask

    task automatic take_word();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (word_valid !== 1'b1 && w < 20);
        n_checks++;
        if (word_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL word_valid_wait: word_valid=%b expected 1 within 20 cycles", word_valid);
        end else begin
            n_checks++;
            if (byte_cnt !== 3'(NBYTES)) begin
                n_fail++;
                $display("[TB] FAIL word_byte_cnt: byte_cnt=%0d expected %0d", byte_cnt, NBYTES);
            end
            word_ready = 1'b1;
            @(posedge clk);
            #1;
            word_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sr_rst, sr_set, sr_in, byte_ready, word_valid, byte_cnt, timeout_err} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: sr_rst=%b sr_set=%b sr_in=%h byte_ready=%b word_valid=%b byte_cnt=%0d timeout_err=%b expected 0 1 00 0 0 0 0",
                     sr_rst, sr_set, sr_in, byte_ready, word_valid, byte_cnt, timeout_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sr_rst !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_cycle: sr_rst=%b byte_ready=%b expected 0 0", sr_rst, byte_ready);
        end
        @(negedge clk);
        n_checks++;
        if (sr_rst !== 1'b1 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collect_entry: sr_rst=%b byte_ready=%b expected 1 1", sr_rst, byte_ready);
        end
    endtask

    task automatic test_word_fill();
        logic [7:0] d[4];
        int acc[4];
        int s0;
        int w = 0;
        d  = '{8'h11, 8'h22, 8'h33, 8'h44};
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            send_byte(d[i]);
            acc[i] = last_acc;
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] !== 3) begin
                n_fail++;
                $display("[TB] FAIL byte_spacing: %0d cycles between accepts, expected 3", acc[i] - acc[i-1]);
            end
        end
        do begin
            @(negedge clk);
            w++;
        end while (word_valid !== 1'b1 && w < 10);
        n_checks++;
        if (word_valid !== 1'b1 || cyc - acc[3] !== 2) begin
            n_fail++;
            $display("[TB] FAIL word_latency: word_valid=%b after %0d cycles, expected 1 after 2", word_valid, cyc - acc[3]);
        end
        n_checks++;
        if (byte_cnt !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL fill_byte_cnt: byte_cnt=%0d expected 4", byte_cnt);
        end
        n_checks++;
        if (strobes - s0 !== 4 || byte_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL fill_strobes: %0d strobes, %0d pending, expected 4 and 0", strobes - s0, byte_q.size());
        end
    endtask

    task automatic test_hold_full();
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (byte_ready !== 1'b0 || word_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL full_hold: byte_ready=%b word_valid=%b expected 0 1", byte_ready, word_valid);
            end
        end
        word_ready = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (word_valid !== 1'b0 || sr_rst !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_release: word_valid=%b sr_rst=%b byte_ready=%b expected 0 0 0", word_valid, sr_rst, byte_ready);
        end
        @(negedge clk);
        n_checks++;
        if (sr_rst !== 1'b1 || byte_ready !== 1'b1 || byte_cnt !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL full_reopen: sr_rst=%b byte_ready=%b byte_cnt=%0d expected 1 1 0", sr_rst, byte_ready, byte_cnt);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA1);
        send_byte(8'hA2);
        wait_ready();
        n_checks++;
        if (byte_cnt !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL partial_cnt: byte_cnt=%0d expected 2", byte_cnt);
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < TIMEOUT && timeout_err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL timeout_early: timeout_err=%b at idle cycle %0d expected 0", timeout_err, k);
            end else if (k == TIMEOUT && (timeout_err !== 1'b1 || sr_rst !== 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL timeout_pulse: timeout_err=%b sr_rst=%b at idle cycle %0d expected 1 0", timeout_err, sr_rst, k);
            end
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || sr_rst !== 1'b1 || byte_ready !== 1'b1 || byte_cnt !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL timeout_recover: timeout_err=%b sr_rst=%b byte_ready=%b byte_cnt=%0d expected 0 1 1 0",
                     timeout_err, sr_rst, byte_ready, byte_cnt);
        end
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        take_word();
    endtask

    task automatic test_expire_priority();
        send_byte(8'hD1);
        send_byte(8'hD2);
        wait_ready();
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
        end
        n_checks++;
        if (byte_ready !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL edge_collect: byte_ready=%b timeout_err=%b expected 1 0", byte_ready, timeout_err);
        end
        byte_in    = 8'hD3;
        byte_valid = 1'b1;
        byte_q.push_back(8'hD3);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || byte_ready !== 1'b0 || sr_rst !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL edge_priority: timeout_err=%b byte_ready=%b sr_rst=%b expected 0 0 1", timeout_err, byte_ready, sr_rst);
        end
        wait_ready();
        n_checks++;
        if (byte_cnt !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL edge_cnt: byte_cnt=%0d expected 3", byte_cnt);
        end
        send_byte(8'hD4);
        take_word();
    endtask

    task automatic test_reset_strobe();
        send_byte(8'hE1);
        send_byte(8'hE2);
        send_byte(8'hE3);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sr_set !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL third_strobe: sr_set=%b expected 0", sr_set);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sr_set !== 1'b1 || sr_rst !== 1'b0 || word_valid !== 1'b0 || byte_cnt !== 3'd0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL strobe_reset: sr_set=%b sr_rst=%b word_valid=%b byte_cnt=%0d byte_ready=%b expected 1 0 0 0 0",
                     sr_set, sr_rst, word_valid, byte_cnt, byte_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        byte_q.delete();
        wait_ready();
        send_byte(8'hF1);
        send_byte(8'hF2);
        send_byte(8'hF3);
        send_byte(8'hF4);
        take_word();
    endtask

`ifdef SRRX_WORD_CNT_EN
    task automatic test_word_count();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        byte_q.delete();
        wait_ready();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < NBYTES; i++) begin
                send_byte(8'(8'h60 + w * 4 + i));
            end
            take_word();
        end
        send_byte(8'h7E);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (timeout_err !== 1'b1 && t < 30);
            n_checks++;
            if (timeout_err !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL count_abort: timeout_err=%b expected 1 within 30 cycles", timeout_err);
            end
        end
        wait_ready();
        n_checks++;
        if (word_count !== 16'd3) begin
            n_fail++;
            $display("[TB] FAIL word_count: word_count=%0d expected 3", word_count);
        end
        force dut.word_cnt = 16'hFFFF;
        #1;
        release dut.word_cnt;
        for (int i = 0; i < NBYTES; i++) begin
            send_byte(8'(8'h90 + i));
        end
        take_word();
        @(negedge clk);
        n_checks++;
        if (word_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL word_count_wrap: word_count=%0d expected 0", word_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word_fill();
        test_hold_full();
        test_timeout();
        test_expire_priority();
        test_reset_strobe();
`ifdef SRRX_WORD_CNT_EN
        test_word_count();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (byte_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d bytes never strobed, expected 0", byte_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
